// File: rtl/tdm_mux4_1.sv
// Four-channel valid/ready TDM merger: round-robin arbitration into a one-word
// output register tagged with the source channel index, plus a transfer counter.
module tdm_mux4_1 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [3:0]          rot_valid;
  logic [1:0]          grant_off;
  logic [1:0]          grant_idx;
  logic                grant_any;
  logic                load_en;
  logic                take;
  logic                out_xfer;

  // Rotate requests so bit 0 is the channel the pointer currently favours.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_valid[gi] = in_valid[2'(ptr_q + 2'(gi))];
    end
  endgenerate

  always_comb begin
    grant_any = |rot_valid;
    grant_off = 2'd3;
    if (rot_valid[0])      grant_off = 2'd0;
    else if (rot_valid[1]) grant_off = 2'd1;
    else if (rot_valid[2]) grant_off = 2'd2;
    grant_idx = ptr_q + grant_off;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q + {15'd0, out_xfer};
    case (state_q)
      EMPTY:   if (take) state_d = FULL;
      FULL:    if (take) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (take) begin
      data_d = in_data[32'(grant_idx)*DATA_W +: DATA_W];
      sel_d  = grant_idx;
      ptr_d  = grant_idx + 2'd1;
    end
  end

  // Outputs; rst_n gates in_ready so it drops at once while reset is held.
  always_comb begin
    load_en   = (state_q == EMPTY) || out_ready;
    take      = load_en && grant_any;
    out_xfer  = (state_q == FULL) && out_ready;
    in_ready  = (take && rst_n) ? (4'b0001 << grant_idx) : 4'b0000;
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = sel_q;
    xfer_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_tdm_mux4_1.sv
// Self-checking bench for tdm_mux4_1: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_tdm_mux4_1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [15:0] xfer_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit       m_full;
  int       m_ptr;
  int       m_data;
  int       m_sel;
  int       m_cnt;

  tdm_mux4_1 #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          rst;
    logic [3:0]  iv;
    logic [31:0] din;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_data = 0; m_sel = 0; m_cnt = 0;
  endtask

  // Called at posedge+1; resets asynchronously and releases away from the edge.
  task automatic do_reset();
    in_valid  = 4'b0;
    out_ready = 1'b0;
    in_data   = 32'h0;
    rst_n     = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_xfer_cnt", {16'd0, xfer_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle against the model: check in_ready now, advance, check outputs.
  task automatic model_step(input string tag);
    int g;
    bit load;
    logic [3:0] exp_rdy;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
      if (g < 0 && in_valid[k]) g = k;
    end
    load    = !m_full || out_ready;
    exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0;
    #1;
    check({tag, "_in_ready"}, {28'd0, in_ready}, {28'd0, exp_rdy});
    if (m_full && out_ready) m_cnt = (m_cnt + 1) % 65536;
    if (load && g >= 0) begin
      m_data = int'((in_data >> (8 * g)) & 32'hFF);
      m_sel  = g;
      m_full = 1;
      m_ptr  = (g + 1) % 4;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_full});
    check({tag, "_out_data"}, {24'd0, out_data}, m_data);
    check({tag, "_out_sel"}, {30'd0, out_sel}, m_sel);
    check({tag, "_xfer_cnt"}, {16'd0, xfer_cnt}, m_cnt);
  endtask

  vec_t vecs[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("por_in_ready", {28'd0, in_ready}, 0);
    check("por_out_valid", {31'd0, out_valid}, 0);
    check("por_out_data", {24'd0, out_data}, 0);
    check("por_out_sel", {30'd0, out_sel}, 0);
    @(posedge clk);
    #1;

    // Single channel, then fairness over all four channels
    vecs.push_back('{1, 4'b0100, 32'h00A5_0000, 1, 4'b0100, 1, 8'hA5, 2'd2, 16'd0});
    vecs.push_back('{0, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'hA5, 2'd2, 16'd1});
    vecs.push_back('{1, 4'b1111, 32'h1312_1110, 1, 4'b0001, 1, 8'h10, 2'd0, 16'd0});
    vecs.push_back('{0, 4'b1111, 32'h1312_1110, 1, 4'b0010, 1, 8'h11, 2'd1, 16'd1});
    vecs.push_back('{0, 4'b1111, 32'h1312_1110, 1, 4'b0100, 1, 8'h12, 2'd2, 16'd2});
    vecs.push_back('{0, 4'b1111, 32'h1312_1110, 1, 4'b1000, 1, 8'h13, 2'd3, 16'd3});
    vecs.push_back('{0, 4'b1111, 32'h1312_1110, 1, 4'b0001, 1, 8'h10, 2'd0, 16'd4});
    vecs.push_back('{0, 4'b0000, 32'h1312_1110, 1, 4'b0000, 0, 8'h10, 2'd0, 16'd5});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
      #1;
      check("vec_in_ready", {28'd0, in_ready}, {28'd0, vecs[i].exp_rdy});
      @(posedge clk);
      #1;
      check("vec_out_valid", {31'd0, out_valid}, {31'd0, vecs[i].exp_vld});
      check("vec_out_data", {24'd0, out_data}, {24'd0, vecs[i].exp_data});
      check("vec_out_sel", {30'd0, out_sel}, {30'd0, vecs[i].exp_sel});
      check("vec_xfer_cnt", {16'd0, xfer_cnt}, {16'd0, vecs[i].exp_cnt});
      $display("vec %0d: iv=%b rdy=%b -> vld=%b data=%h sel=%0d cnt=%0d",
               i, vecs[i].iv, in_ready, out_valid, out_data, out_sel, xfer_cnt);
    end

    // Backpressure: ch1 word held while out_ready is low
    do_reset();
    in_valid = 4'b0010; in_data = 32'h0000_3C00; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 4'b1111; in_data = 32'h4443_4241;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", {28'd0, in_ready}, 0);
      @(posedge clk); #1;
      check("bp_out_data", {24'd0, out_data}, 32'h3C);
      check("bp_out_sel", {30'd0, out_sel}, 1);
      check("bp_out_valid", {31'd0, out_valid}, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {28'd0, in_ready}, 32'b0100);
    @(posedge clk); #1;
    check("bp_release_sel", {30'd0, out_sel}, 2);
    check("bp_release_data", {24'd0, out_data}, 32'h43);
    $display("backpressure: sel=%0d data=%h cnt=%0d", out_sel, out_data, xfer_cnt);

    // Skip idle: with ptr=1, only ch0 requesting
    do_reset();
    in_valid = 4'b0001; in_data = 32'h0000_0077; out_ready = 1'b1;
    @(posedge clk); #1;
    #1;
    check("skip_in_ready", {28'd0, in_ready}, 32'b0001);
    @(posedge clk); #1;
    check("skip_out_sel", {30'd0, out_sel}, 0);
    in_valid = 4'b1111;
    #1;
    check("skip_ptr_after", {28'd0, in_ready}, 32'b0010);
    $display("skip idle: sel=%0d next_rdy=%b", out_sel, in_ready);

    // Reset mid-operation with a word held and xfer_cnt=7
    do_reset();
    in_valid = 4'b1111; in_data = 32'hDDCC_BBAA; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) model_step("pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_xfer_cnt", {16'd0, xfer_cnt}, 0);
    check("mid_rst_in_ready", {28'd0, in_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    model_step("post_rst");
    $display("reset mid-op: post sel=%0d cnt=%0d", out_sel, xfer_cnt);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      model_step("rnd");
    end
    $display("random: %0d cycles, cnt=%0d", 400, xfer_cnt);

    // Counter wrap
    do_reset();
    in_valid = 4'b1111; in_data = 32'h0403_0201; out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("wrap_pre", {16'd0, xfer_cnt}, 32'd65535);
    @(posedge clk); #1;
    check("wrap_zero", {16'd0, xfer_cnt}, 0);
    $display("wrap: cnt=%0d", xfer_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
